// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button pulse generator.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESS_CHK = 2'd1,
      ST_HELD      = 2'd2,
      ST_REL_CHK   = 2'd3
   } btn_state_t;

   localparam int DEF_DEB_CYCLES = 4;
   localparam int DEF_REP_DELAY  = 16;
   localparam int DEF_REP_PERIOD = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; both flops clear on reset.
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounced button to one-cycle pulse generator with saturating press counter.
// Optional auto-repeat while held is enabled by defining BTN_PULSE_GEN_AUTO_REPEAT_EN.
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int REP_DELAY  = DEF_REP_DELAY,
   parameter int REP_PERIOD = DEF_REP_PERIOD
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_in,
   output logic       pulse,
   output logic       level,
   output logic [7:0] press_cnt,
   output btn_state_t state_dbg
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   // The cycle that enters PRESS_CHK/REL_CHK already counts as the first stable one.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 2);

   if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || REP_PERIOD < 2 || REP_DELAY < 2) begin : g_param_check
      $error("btn_pulse_gen: timing parameter out of range");
   end

   logic          btn_s;
   btn_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          pulse_n, level_n;

   sync_2ff u_sync (
      .clock (clock),
      .reset (reset),
      .d     (btn_in),
      .q     (btn_s)
   );

`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
   localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int RW      = $clog2(REP_MAX + 1);

   logic [RW-1:0] rep_cnt, rep_cnt_n, rep_limit;
   logic          rep_phase, rep_phase_n;

   assign rep_limit = rep_phase ? RW'(REP_PERIOD - 1) : RW'(REP_DELAY - 1);
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pulse_n = 1'b0;
      level_n = level;
      case (state)
         ST_IDLE: begin
            if (btn_s) begin
               state_n = ST_PRESS_CHK;
               cnt_n   = '0;
            end
         end
         ST_PRESS_CHK: begin
            if (!btn_s) begin
               state_n = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_HELD;
               pulse_n = 1'b1;
               level_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_HELD: begin
            if (!btn_s) begin
               state_n = ST_REL_CHK;
               cnt_n   = '0;
            end
         end
         ST_REL_CHK: begin
            if (btn_s) begin
               state_n = ST_HELD;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_IDLE;
               level_n = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
      rep_cnt_n   = rep_cnt;
      rep_phase_n = rep_phase;
      // Timer only runs through uninterrupted HELD cycles; anything else restarts the delay.
      if (state != ST_HELD || !btn_s) begin
         rep_cnt_n   = '0;
         rep_phase_n = 1'b0;
      end else if (rep_cnt == rep_limit) begin
         pulse_n     = 1'b1;
         rep_cnt_n   = '0;
         rep_phase_n = 1'b1;
      end else begin
         rep_cnt_n = rep_cnt + 1'b1;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         pulse     <= 1'b0;
         level     <= 1'b0;
         press_cnt <= 8'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pulse <= pulse_n;
         level <= level_n;
         if (pulse && press_cnt != 8'hFF) begin
            press_cnt <= press_cnt + 8'd1;
         end
      end
   end

`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else begin
         rep_cnt   <= rep_cnt_n;
         rep_phase <= rep_phase_n;
      end
   end
`endif

   assign state_dbg = state;

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 Parameter: DEB_CYCLES, 4, consecutive synchronized cycles an input level must hold to be accepted (legal range 2..255).
REQ-002 Parameter: REP_DELAY, 16, cycles in HELD before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
REQ-003 Parameter: REP_PERIOD, 4, cycles between auto-repeat pulses (legal minimum 2).
REQ-004 Port: clock  input  1  system clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  reset, synchronous, active-high.
REQ-006 Port: btn_in  input  1  raw asynchronous button level, bouncing allowed.
REQ-007 Port: pulse  output  1  one-cycle strobe per accepted press; feeds the downstream counter's count-enable input.
REQ-008 Port: level  output  1  debounced button level.
REQ-009 Port: press_cnt  output  8  saturating count of emitted pulses.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer; its output btn_s is the only signal the FSM samples.
REQ-011 FSM states SHALL be IDLE, PRESS_CHK, HELD, REL_CHK; one stability counter, width ceil(log2(DEB_CYCLES+1)).
REQ-012 IDLE: btn_s=1 -> PRESS_CHK with counter cleared; otherwise stay in IDLE.
REQ-013 PRESS_CHK: btn_s=0 -> IDLE, no pulse (glitch rejected); btn_s=1 for DEB_CYCLES consecutive cycles -> HELD.
REQ-014 If btn_s first rises in cycle t and stays high, pulse SHALL be high exactly in cycle t+DEB_CYCLES and level SHALL rise in the same cycle.
REQ-015 HELD: btn_s=0 -> REL_CHK with counter cleared.
REQ-016 REL_CHK: btn_s=1 -> HELD with no new pulse (release bounce); btn_s=0 for DEB_CYCLES consecutive cycles -> IDLE, level falls in the cycle IDLE is entered.
REQ-017 pulse SHALL be registered, glitch-free, and never high for two consecutive cycles, so a consumer sampling on either clock edge sees exactly one count.
REQ-018 press_cnt SHALL increment in every cycle pulse is high and saturate at 255 (no wrap).

Reset
REQ-019 Reset SHALL clear both synchronizer flops, FSM to IDLE, all counters to 0, pulse=0, level=0, press_cnt=0.
REQ-020 Reset SHALL take priority over every other event; reset asserted mid-debounce or in HELD aborts with no pulse.
REQ-021 A button held through reset release SHALL be treated as a new press: pulse in cycle 2+DEB_CYCLES after the first non-reset cycle.

Configuration
REQ-022 Macro BTN_PULSE_GEN_AUTO_REPEAT_EN defined: after REP_DELAY continuous cycles in HELD, pulse fires, then every REP_PERIOD cycles while in HELD; each repeat increments press_cnt.
REQ-023 The repeat timer SHALL clear on entry to REL_CHK; returning to HELD restarts the REP_DELAY wait.
REQ-024 Macro undefined: no repeat logic synthesized; exactly one pulse per accepted press.

Structure
REQ-025 Package btn_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default DEB_CYCLES, REP_DELAY and REP_PERIOD constants.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, reset-clearable).

Verification
REQ-027 Clean press: btn_in 0->1 held 20 cycles, DEB_CYCLES=4 -> one pulse at btn_s-rise+4, level=1, press_cnt=1.
REQ-028 Bounce: btn_in high 3 cycles, low 1 cycle, then high steadily -> no pulse during the bounce; one pulse 4 cycles after the final rise is synchronized.
REQ-029 Release bounce: in HELD, btn_in low 2 cycles, high 1 cycle, then low -> no extra pulse; level falls 4 cycles after the last synchronized fall.
REQ-030 Saturation: 260 clean presses -> press_cnt stops at 255; pulse count observed on the bus is 260.
REQ-031 Reset mid-op: reset asserted for 1 cycle in PRESS_CHK with the button held -> no pulse, outputs 0; pulse at cycle 6 after reset release.
REQ-032 Auto-repeat (macro on, REP_DELAY=16, REP_PERIOD=4): hold for 40 cycles after acceptance -> pulses at acceptance, +16, +20, +24, ..., +36; press_cnt=7.
